// File: rtl/pattern_pkg.sv
// pattern_pkg: shared state encoding and default constants for the pattern stream blocks
package pattern_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int STREAM_WIDTH = 30;
  localparam int PAT_WIDTH = 4;
  localparam logic [3:0] PATTERN = 4'b1011;
endpackage

// File: rtl/pattern_sent_marker.sv
// pattern_sent_marker: history of valid stream bits with a registered match flag (built only with PATTERN_MARK_EN)
`ifdef PATTERN_MARK_EN
module pattern_sent_marker #(
  parameter int N = 4,
  parameter logic [N-1:0] MATCH = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic bit_valid,
  input  logic bit_in,
  output logic hit
);
  logic [N-1:0] hist;
  logic [N-1:0] nxt_hist;
  assign nxt_hist = {hist[N-2:0], bit_in};
  // shift history only on bits that will be presented as valid; flag aligns with that bit
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      hit <= 1'b0;
    end else begin
      hit <= bit_valid && nxt_hist == MATCH;
      if (bit_valid) hist <= nxt_hist;
    end
  end
endmodule
`endif

// File: rtl/pattern_stream_gen.sv
// pattern_stream_gen: MSB-first serializer with valid/last qualifiers; PATTERN_MARK_EN adds pattern_sent
module pattern_stream_gen
  import pattern_pkg::*;
#(
  parameter int WIDTH = STREAM_WIDTH,
  parameter int LEN_W = $clog2(WIDTH + 1)
`ifdef PATTERN_MARK_EN
  ,
  parameter int PAT_WIDTH = pattern_pkg::PAT_WIDTH,
  parameter logic [PAT_WIDTH-1:0] PATTERN = pattern_pkg::PATTERN
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             stream_out,
  output logic             stream_valid,
  output logic             stream_last,
  output logic             busy
`ifdef PATTERN_MARK_EN
  ,
  output logic             pattern_sent
`endif
);
  state_t state, nxt_state;
  logic [WIDTH-1:0] shreg, nxt_shreg;
  logic [LEN_W-1:0] remaining, nxt_remaining, eff_len;
  logic last_bit, accept;
  assign last_bit = state == SHIFT && remaining == LEN_W'(1);
  assign load_ready = !reset && (state == IDLE || last_bit);
  assign accept = load_valid && load_ready;
  assign eff_len = (load_len == '0 || load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
  // next word/shift state; a load in the final-bit cycle chains the next word with no gap
  always_comb begin
    nxt_state = accept ? SHIFT : last_bit ? IDLE : state;
    nxt_shreg = accept ? load_data : shreg << 1;
    nxt_remaining = accept ? eff_len : state == SHIFT ? remaining - LEN_W'(1) : remaining;
  end
  // state plus outputs registered from the next state so they describe the bit now on stream_out
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      remaining <= '0;
      stream_out <= 1'b0;
      stream_valid <= 1'b0;
      stream_last <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt_state;
      shreg <= nxt_shreg;
      remaining <= nxt_remaining;
      stream_out <= nxt_state == SHIFT && nxt_shreg[WIDTH-1];
      stream_valid <= nxt_state == SHIFT;
      stream_last <= nxt_state == SHIFT && nxt_remaining == LEN_W'(1);
      busy <= nxt_state == SHIFT;
    end
  end
`ifdef PATTERN_MARK_EN
  pattern_sent_marker #(.N(PAT_WIDTH), .MATCH(PATTERN)) u_marker (
    .clk(clk),
    .reset(reset),
    .bit_valid(nxt_state == SHIFT),
    .bit_in(nxt_shreg[WIDTH-1]),
    .hit(pattern_sent)
  );
`endif
endmodule

// File: tb/tb_pattern_stream_gen.sv
// tb_pattern_stream_gen: queue-of-bits reference model checked every cycle, plus directed literal checks
module tb_pattern_stream_gen;
  localparam int W = 30;
  localparam int LW = $clog2(W + 1);
  localparam logic [W-1:0] W1 = 30'b111011010101101001010011010110;
  localparam logic [W-1:0] W2 = 30'h2AAA5555;
  typedef struct {logic b; logic l;} ent_t;
  typedef struct {logic b; logic l; logic p; int c;} obs_t;
  logic clk = 0, reset = 1, load_valid = 0;
  logic [W-1:0] load_data = '0;
  logic [LW-1:0] load_len = '0;
  logic load_ready, stream_out, stream_valid, stream_last, busy, pattern_sent;
  int checks = 0, failures = 0, cyc_n = 0, caps = 0;
  ent_t q[$];
  obs_t obs[$];
  logic [3:0] hist = '0;
  logic exp_ps = 1'b0;

  pattern_stream_gen dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data(load_data),
    .load_len(load_len),
    .stream_out(stream_out),
    .stream_valid(stream_valid),
    .stream_last(stream_last),
    .busy(busy)
`ifdef PATTERN_MARK_EN
    ,
    .pattern_sent(pattern_sent)
`endif
  );
`ifndef PATTERN_MARK_EN
  assign pattern_sent = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  // model: q holds the bits still to be presented, front = bit on the wire now
  always @(negedge clk) begin
    bit acc;
    int len;
    cyc_n++;
    chk("load_ready", load_ready, !reset && q.size() <= 1);
    chk("stream_valid", stream_valid, q.size() > 0);
    chk("stream_out", stream_out, q.size() > 0 && q[0].b);
    chk("stream_last", stream_last, q.size() > 0 && q[0].l);
    chk("busy", busy, q.size() > 0);
`ifdef PATTERN_MARK_EN
    chk("pattern_sent", pattern_sent, exp_ps);
`endif
    if (stream_valid) obs.push_back('{stream_out, stream_last, pattern_sent, cyc_n});
    if (load_valid && load_ready) caps++;
    if (reset) begin
      q.delete();
      hist = '0;
      exp_ps = 1'b0;
    end else begin
      acc = load_valid && q.size() <= 1;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        len = (load_len == 0 || load_len > W) ? W : int'(load_len);
        for (int i = 0; i < len; i++) q.push_back('{load_data[W-1-i], i == len - 1});
      end
      exp_ps = 1'b0;
      if (q.size() > 0) begin
        hist = {hist[2:0], q[0].b};
        exp_ps = hist == 4'b1011;
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(logic [W-1:0] d, logic [LW-1:0] l);
    int t = 0;
    load_valid = 1;
    load_data = d;
    load_len = l;
    while (!load_ready && t < 100) begin
      cycles(1);
      t++;
    end
    chk("send_timeout", t < 100, 1);
    cycles(1);
    load_valid = 0;
  endtask

  function automatic logic [31:0] field(int n, int f);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++)
      r = {r[30:0], i < obs.size() ? (f == 0 ? obs[i].b : f == 1 ? obs[i].l : obs[i].p) : 1'b0};
    return r;
  endfunction

  initial begin
    logic [W-1:0] w;
    int n;
    @(posedge clk);
    #1;
    chk("reset_valid", stream_valid, 0);
    chk("reset_busy", busy, 0);
    reset = 0;
    cycles(1);
    obs.delete();
    send(W1, 30);
    cycles(31);
    chk("basic_count", obs.size(), 30);
    chk("basic_word", field(30, 0), W1);
    chk("basic_last", field(30, 1), 32'h1);
    chk("basic_idle_busy", busy, 0);
    obs.delete();
    send(30'(4'b1011) << 26, 4);
    send(30'(3'b010) << 27, 3);
    cycles(4);
    chk("b2b_count", obs.size(), 7);
    chk("b2b_bits", field(7, 0), 7'b1011010);
    chk("b2b_last", field(7, 1), 7'b0001001);
    chk("b2b_nogap", obs.size() >= 7 ? obs[6].c - obs[0].c : -1, 6);
    obs.delete();
    send(30'(8'hC5) << 22, 8);
    caps = 0;
    load_valid = 1;
    load_data = 30'(3'b110) << 27;
    load_len = 3;
    n = 0;
    while (!load_ready && n < 50) begin
      cycles(1);
      n++;
    end
    cycles(1);
    load_valid = 0;
    cycles(4);
    chk("stall_wait", n, 7);
    chk("stall_caps", caps, 1);
    chk("stall_bits", field(11, 0), 11'b11000101110);
    chk("stall_last", field(11, 1), 11'b00000001001);
    obs.delete();
    send(30'h2000_0000, 1);
    cycles(2);
    chk("len1_count", obs.size(), 1);
    chk("len1_bit_last", field(1, 0) << 1 | field(1, 1), 2'b11);
    obs.delete();
    send(W2, 0);
    cycles(31);
    chk("len0_count", obs.size(), 30);
    chk("len0_word", field(30, 0), W2);
    obs.delete();
    send(W1, 31);
    cycles(31);
    chk("len31_count", obs.size(), 30);
    obs.delete();
    send(W1, 30);
    cycles(4);
    reset = 1;
    cycles(1);
    reset = 0;
    chk("rst_mid_valid", stream_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_last", stream_last, 0);
    w = W1;
    chk("rst_mid_count", obs.size(), 5);
    chk("rst_mid_bits", field(5, 0), w[29:25]);
    chk("rst_mid_nolast", field(5, 1), 0);
    obs.delete();
    send(W2, 30);
    cycles(31);
    chk("after_rst_word", field(30, 0), W2);
`ifdef PATTERN_MARK_EN
    reset = 1;
    cycles(1);
    reset = 0;
    obs.delete();
    send(30'(7'b1011011) << 23, 7);
    cycles(8);
    chk("mark_hits", field(7, 2), 7'b0001001);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pattern_stream_gen.md
Name: pattern_stream_gen

Overview:
- Serial bit-stream transmitter that produces the single-bit stream consumed by pattern_detector_fsm.
- Accepts parallel words over a valid/ready handshake and emits them MSB-first, one bit per clk, with a valid qualifier and a last marker.
- Used as the stimulus source for the detector in system-level benches.
- Also used as the serializer in front of any downstream bit-serial consumer.

Parameters:
- WIDTH, 30, width of load_data; maximum bits per word.
- LEN_W, $clog2(WIDTH+1), width of load_len.
- PAT_WIDTH, 4, width of the marker pattern (optional feature only).
- PATTERN, 4'b1011, pattern that pattern_sent flags (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high.
- load_valid  input  1  a word is offered on load_data/load_len.
- load_ready  output  1  generator accepts a word this cycle.
- load_data  input  WIDTH  word, left-aligned; bit WIDTH-1 is sent first.
- load_len  input  LEN_W  number of bits to send, 1..WIDTH; 0 or >WIDTH means WIDTH.
- stream_out  output  1  serial data bit (the detector's stream_in).
- stream_valid  output  1  stream_out carries a real bit this cycle.
- stream_last  output  1  the current bit is the last bit of the word.
- busy  output  1  a word is being shifted.
- pattern_sent  output  1  (PATTERN_MARK_EN only) the last PAT_WIDTH valid bits sent equal PATTERN.

Behaviour:
- Reset is synchronous and active-high.
- While reset=1, load_ready=0 and all registered outputs are 0 at the next edge: stream_out, stream_valid, stream_last, busy, pattern_sent.
- State resets to IDLE and the remaining-bit count to 0.
- States:
  - IDLE: busy=0, stream_valid=0, stream_out=0.
  - SHIFT: a word is in the shift register and remaining>0.
- load_ready is combinational: !reset && (state==IDLE || (state==SHIFT && remaining==1)).
- A load is accepted on an edge where load_valid && load_ready.
- On acceptance:
  - shreg <= load_data.
  - remaining <= effective length.
  - state <= SHIFT.
- Outputs are registered. The first bit appears in the cycle after acceptance: stream_valid=1, stream_out=load_data[WIDTH-1].
- Each following cycle in SHIFT:
  - shreg shifts left by 1 and remaining decrements.
  - stream_out=shreg MSB.
  - stream_valid=1.
- stream_last=1 exactly in the cycle the final bit is presented (remaining==1).
- Latency from acceptance to the last bit is L cycles, L = effective length.
- Back-to-back words: a load accepted in the final-bit cycle makes the next word's first bit appear in the immediately following cycle. There is no gap and stream_valid stays 1.
- If no load is accepted in the final-bit cycle, the block returns to IDLE: stream_valid=0 and stream_out=0 next cycle.
- load_valid while load_ready=0: ignored; the word is not captured. The producer must hold it.
- Reset mid-word aborts the word. Remaining bits are discarded and no stream_last is produced.
- len=1: a single bit, with stream_valid and stream_last both 1 for one cycle.

Optional Feature:
- Macro PATTERN_MARK_EN.
- Defined:
  - Keep a PAT_WIDTH-bit history of bits sent with stream_valid=1. The history is shifted only on valid bits and cleared by reset.
  - pattern_sent=1 in the same cycle that the bit completing PATTERN is on stream_out, including overlapping matches and matches spanning word boundaries.
  - The history persists across IDLE gaps.
  - Serves as a golden reference for checking the detector.
- Undefined: the pattern_sent port is absent and no history logic is built.

Decomposition:
- Package pattern_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - default constants STREAM_WIDTH=30, PAT_WIDTH=4, PATTERN=4'b1011.
- pattern_detector_fsm also imports pattern_pkg.
- One natural sub-module: pattern_sent_marker, the PAT_WIDTH history plus compare. It is instantiated only under PATTERN_MARK_EN.

Test Plan:
- Basic word: reset 1 cycle, then load 30'b111011010101101001010011010110 with len=30. Stream equals that value MSB-first over 30 cycles; stream_last only on cycle 30; busy=0 after.
- Back-to-back: word A (len=4, data 1011<<26) then word B (len=3, data 010<<27) offered in A's last cycle. Stream is 1011010 with no invalid gap; stream_last on bits 4 and 7.
- Stall: hold load_valid=1 mid-word. load_ready=0 until the final-bit cycle; exactly one capture occurs; bits are not duplicated.
- Length edges:
  - len=1 with data MSB=1 gives one valid bit '1' with stream_last=1.
  - len=0 sends all 30 bits.
- Reset mid-word: assert reset after 5 bits of a 30-bit word. The next cycle shows stream_valid=0, busy=0 and no stream_last; a new load afterwards starts from bit WIDTH-1.
- PATTERN_MARK_EN: stream 1011011 gives pattern_sent on bits 4 and 7 (overlap). Pairing with pattern_detector_fsm, pattern_found matches pattern_sent at a fixed offset.
